// File: rtl/vram_write_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_write_arbiter_if : VRAM write bus, presented entry held until ack      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface vram_write_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              sel;
   logic              wr;
   logic [3:0]        mask;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_out;
   logic              ack;

   modport master (output sel, wr, mask, addr, data_out, input ack);
   modport slave  (input sel, wr, mask, addr, data_out, output ack);
endinterface
`default_nettype wire

// File: rtl/vram_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_write_arbiter : two-source write FIFOs drained onto one VRAM write    |
// | port by a burst-limited round-robin scheduler.            Rev 1.0          |
// +----------------------------------------------------------------------------+
module vram_write_arbiter #(
   parameter int DEPTH  = 4,
   parameter int BURST  = 8,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                 clk,
   input  logic                 reset_i,
   input  logic                 gfx_sel_i,
   input  logic                 gfx_wr_i,
   input  logic [3:0]           gfx_mask_i,
   input  logic [ADDR_W-1:0]    gfx_addr_i,
   input  logic [DATA_W-1:0]    gfx_data_i,
   output logic                 gfx_full_o,
   output logic                 gfx_overflow_o,
   input  logic                 host_sel_i,
   input  logic                 host_wr_i,
   input  logic [3:0]           host_mask_i,
   input  logic [ADDR_W-1:0]    host_addr_i,
   input  logic [DATA_W-1:0]    host_data_i,
   output logic                 host_full_o,
   output logic                 host_overflow_o,
   vram_write_arbiter_if.master vram,
   output logic                 grant_host_o,
   output logic                 busy_o
);
   localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                 c_CNT_W = c_PTR_W + 1;
   localparam int                 c_ENT_W = 4 + ADDR_W + DATA_W;
   localparam int                 c_BST_W = $clog2(BURST + 1);
   localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
   localparam logic [c_BST_W-1:0] c_BURST = c_BST_W'(BURST);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_t;

   state_t r_state, w_state_nxt;

   // Index 0 is gfx, index 1 is host.
   logic [1:0]              w_req, w_push, w_pop, w_avail, w_nempty, w_full, w_ovf;
   logic [1:0][c_ENT_W-1:0] w_in, w_head;

   logic               r_grant_host, r_first;
   logic [c_BST_W-1:0] r_burst, w_burst_nxt;
   logic [3:0]         r_mask;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_data;
   logic               w_sel, w_ack, w_load, w_pick_host;
   logic [c_ENT_W-1:0] w_entry;

   assign w_req   = {host_sel_i & host_wr_i, gfx_sel_i & gfx_wr_i};
   assign w_in[0] = {gfx_mask_i, gfx_addr_i, gfx_data_i};
   assign w_in[1] = {host_mask_i, host_addr_i, host_data_i};

   assign w_sel = (r_state == S_ISSUE);
   assign w_ack = w_sel & vram.ack;
   assign w_pop = {w_ack & r_grant_host, w_ack & ~r_grant_host};

   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [c_ENT_W-1:0] r_mem [DEPTH];
      logic [c_PTR_W-1:0] r_wptr, r_rptr;
      logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
      logic               r_full, r_ovf;

      assign w_push[gi] = w_req[gi] & ~r_full;
      assign w_cnt_nxt  = r_cnt + c_CNT_W'(w_push[gi]) - c_CNT_W'(w_pop[gi]);

      always_ff @(posedge clk) begin
         if (w_push[gi]) begin
            r_mem[r_wptr] <= w_in[gi];
         end
      end

      always_ff @(posedge clk) begin
         if (reset_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
            r_ovf  <= 1'b0;
         end else begin
            if (w_push[gi]) begin
               r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop[gi]) begin
               r_rptr <= r_rptr + 1'b1;
            end
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == c_DEPTH);
            // A dropped push is sticky even if a pop frees a slot this cycle.
            if (w_req[gi] & r_full) begin
               r_ovf <= 1'b1;
            end
         end
      end

      // Eligibility and head look past the pop in flight; same-cycle pushes are invisible.
      assign w_nempty[gi] = (r_cnt != '0);
      assign w_avail[gi]  = (r_cnt > c_CNT_W'(w_pop[gi]));
      assign w_head[gi]   = r_mem[r_rptr + c_PTR_W'(w_pop[gi])];
      assign w_full[gi]   = r_full;
      assign w_ovf[gi]    = r_ovf;
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_pick_host = w_avail[1];
      w_burst_nxt = r_burst;
      if ((r_state == S_IDLE) || vram.ack) begin
         w_load      = |w_avail;
         w_state_nxt = (|w_avail) ? S_ISSUE : S_IDLE;
      end
      if (w_avail[0] && w_avail[1]) begin
         if (r_state == S_IDLE) begin
            w_pick_host = r_first ? 1'b0 : ~r_grant_host;
         end else begin
            w_pick_host = (r_burst < c_BURST) ? r_grant_host : ~r_grant_host;
         end
      end
      if (w_pick_host != r_grant_host) begin
         w_burst_nxt = c_BST_W'(1);
      end else if (r_burst < c_BURST) begin
         w_burst_nxt = r_burst + 1'b1;
      end
   end

   assign w_entry = w_pick_host ? w_head[1] : w_head[0];

   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_grant_host <= 1'b0;
         r_first      <= 1'b1;
         r_burst      <= '0;
         r_mask       <= '0;
         r_addr       <= '0;
         r_data       <= '0;
      end else if (w_load) begin
         r_grant_host <= w_pick_host;
         r_first      <= 1'b0;
         r_burst      <= w_burst_nxt;
         r_mask       <= w_entry[c_ENT_W-1 -: 4];
         r_addr       <= w_entry[DATA_W +: ADDR_W];
         r_data       <= w_entry[DATA_W-1:0];
      end
   end

   assign vram.sel        = w_sel;
   assign vram.wr         = w_sel;
   assign vram.mask       = r_mask;
   assign vram.addr       = r_addr;
   assign vram.data_out   = r_data;
   assign gfx_full_o      = w_full[0];
   assign host_full_o     = w_full[1];
   assign gfx_overflow_o  = w_ovf[0];
   assign host_overflow_o = w_ovf[1];
   assign grant_host_o    = r_grant_host;
   assign busy_o          = w_sel | (|w_nempty);
endmodule
`default_nettype wire

// File: tb/tb_vram_write_arbiter.sv
`default_nettype none
// Bench for vram_write_arbiter: per-cycle vector table plus directed reset/latency sequences.
module tb_vram_write_arbiter;
   localparam int DEPTH  = 4;
   localparam int BURST  = 2;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              reset_i = 1'b1;
   logic              gfx_sel_i = 1'b0, gfx_wr_i = 1'b0;
   logic [3:0]        gfx_mask_i = '0;
   logic [ADDR_W-1:0] gfx_addr_i = '0;
   logic [DATA_W-1:0] gfx_data_i = '0;
   logic              host_sel_i = 1'b0, host_wr_i = 1'b0;
   logic [3:0]        host_mask_i = '0;
   logic [ADDR_W-1:0] host_addr_i = '0;
   logic [DATA_W-1:0] host_data_i = '0;
   logic              gfx_full_o, gfx_overflow_o, host_full_o, host_overflow_o;
   logic              grant_host_o, busy_o;

   vram_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) vif ();

   vram_write_arbiter #(
      .DEPTH(DEPTH), .BURST(BURST), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .reset_i(reset_i),
      .gfx_sel_i(gfx_sel_i), .gfx_wr_i(gfx_wr_i), .gfx_mask_i(gfx_mask_i),
      .gfx_addr_i(gfx_addr_i), .gfx_data_i(gfx_data_i),
      .gfx_full_o(gfx_full_o), .gfx_overflow_o(gfx_overflow_o),
      .host_sel_i(host_sel_i), .host_wr_i(host_wr_i), .host_mask_i(host_mask_i),
      .host_addr_i(host_addr_i), .host_data_i(host_data_i),
      .host_full_o(host_full_o), .host_overflow_o(host_overflow_o),
      .vram(vif),
      .grant_host_o(grant_host_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        g_push;
      logic [15:0] g_addr;
      logic        h_push;
      logic [15:0] h_addr;
      logic        ack;
      logic        e_sel;
      logic [15:0] e_addr;
      logic        e_host;
      logic        e_busy;
      logic        e_gfull;
      logic        e_govf;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [15:0] dat_of(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   function automatic logic [3:0] msk_of(input logic [15:0] a);
      return a[3:0] ^ a[7:4];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic rst, input logic gp, input logic [15:0] ga,
                      input logic hp, input logic [15:0] ha, input logic ack,
                      input logic es, input logic [15:0] ea, input logic eh,
                      input logic eb, input logic egf, input logic ego);
      vec_t v;
      v.rst = rst; v.g_push = gp; v.g_addr = ga; v.h_push = hp; v.h_addr = ha;
      v.ack = ack; v.e_sel = es; v.e_addr = ea; v.e_host = eh; v.e_busy = eb;
      v.e_gfull = egf; v.e_govf = ego;
      tbl.push_back(v);
   endtask

   task automatic apply(input vec_t v);
      reset_i     = v.rst;
      gfx_sel_i   = v.g_push;  gfx_wr_i  = v.g_push;
      gfx_addr_i  = v.g_addr;  gfx_data_i = dat_of(v.g_addr); gfx_mask_i = msk_of(v.g_addr);
      host_sel_i  = v.h_push;  host_wr_i = v.h_push;
      host_addr_i = v.h_addr;  host_data_i = dat_of(v.h_addr); host_mask_i = msk_of(v.h_addr);
      vif.ack     = v.ack;
   endtask

   task automatic idle_inputs(input logic ack);
      gfx_sel_i = 1'b0; gfx_wr_i = 1'b0; host_sel_i = 1'b0; host_wr_i = 1'b0;
      vif.ack = ack;
   endtask

   initial begin
      // Stall on a single gfx source, then fill to overflow and drain.
      add(0, 1, 16'h0020, 0, 0, 0,  0, 16'h0000, 0, 1, 0, 0);
      add(0, 1, 16'h0021, 0, 0, 0,  1, 16'h0020, 0, 1, 0, 0);
      for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, 0,  1, 16'h0020, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1,  1, 16'h0021, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1,  0, 16'h0000, 0, 0, 0, 0);
      add(0, 1, 16'h0030, 0, 0, 0,  0, 16'h0000, 0, 1, 0, 0);
      add(0, 1, 16'h0031, 0, 0, 0,  1, 16'h0030, 0, 1, 0, 0);
      add(0, 1, 16'h0032, 0, 0, 0,  1, 16'h0030, 0, 1, 0, 0);
      add(0, 1, 16'h0033, 0, 0, 0,  1, 16'h0030, 0, 1, 1, 0);
      add(0, 1, 16'h0034, 0, 0, 0,  1, 16'h0030, 0, 1, 1, 1);
      add(0, 1, 16'h0035, 0, 0, 0,  1, 16'h0030, 0, 1, 1, 1);
      add(0, 0, 0, 0, 0, 1,  1, 16'h0031, 0, 1, 0, 1);
      add(0, 0, 0, 0, 0, 1,  1, 16'h0032, 0, 1, 0, 1);
      add(0, 0, 0, 0, 0, 1,  1, 16'h0033, 0, 1, 0, 1);
      add(0, 0, 0, 0, 0, 1,  0, 16'h0000, 0, 0, 0, 1);
      // Reset, then both sources contend with BURST=2.
      add(1, 0, 0, 0, 0, 0,  0, 16'h0000, 0, 0, 0, 0);
      add(0, 1, 16'h0100, 1, 16'h0200, 0,  0, 16'h0000, 0, 1, 0, 0);
      add(0, 1, 16'h0101, 1, 16'h0201, 0,  1, 16'h0100, 0, 1, 0, 0);
      add(0, 1, 16'h0102, 1, 16'h0202, 0,  1, 16'h0100, 0, 1, 0, 0);
      add(0, 1, 16'h0103, 0, 0, 1,  1, 16'h0101, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1,  1, 16'h0200, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1,  1, 16'h0201, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1,  1, 16'h0102, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1,  1, 16'h0103, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1,  1, 16'h0202, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1,  0, 16'h0000, 1, 0, 0, 0);
      // Host alone streams past the burst limit.
      add(0, 0, 0, 1, 16'h0300, 0,  0, 16'h0000, 1, 1, 0, 0);
      add(0, 0, 0, 1, 16'h0301, 0,  1, 16'h0300, 1, 1, 0, 0);
      add(0, 0, 0, 1, 16'h0302, 1,  1, 16'h0301, 1, 1, 0, 0);
      add(0, 0, 0, 1, 16'h0303, 1,  1, 16'h0302, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1,  1, 16'h0303, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1,  0, 16'h0000, 1, 0, 0, 0);

      vif.ack = 1'b0;
      reset_i = 1'b1;
      step();
      step();
      chk("reset_state",
          {vif.sel, vif.wr, vif.mask, vif.addr, vif.data_out, gfx_full_o, gfx_overflow_o,
           host_full_o, host_overflow_o, grant_host_o, busy_o}, 64'h0);
      reset_i = 1'b0;
      step();

      // sel without wr must not enqueue.
      gfx_sel_i = 1'b1; gfx_wr_i = 1'b0; gfx_addr_i = 16'h0099;
      step();
      idle_inputs(1'b0);
      step();
      chk("sel_without_wr", {vif.sel, busy_o}, 2'b00);

      // Single write, ack tied high: one-cycle presentation two edges after the push.
      vif.ack = 1'b1;
      gfx_sel_i = 1'b1; gfx_wr_i = 1'b1;
      gfx_addr_i = 16'h0010; gfx_data_i = 16'hF0F0; gfx_mask_i = 4'hF;
      step();
      chk("single_after_push", {vif.sel, busy_o}, 2'b01);
      idle_inputs(1'b1);
      step();
      chk("single_present", {vif.sel, vif.wr, vif.addr, vif.data_out, vif.mask},
          {1'b1, 1'b1, 16'h0010, 16'hF0F0, 4'hF});
      step();
      chk("single_done", {vif.sel, busy_o}, 2'b00);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
         step();
         chk($sformatf("vec%0d_ctrl", i),
             {vif.sel, vif.wr, grant_host_o, busy_o, gfx_full_o, gfx_overflow_o,
              host_full_o, host_overflow_o},
             {tbl[i].e_sel, tbl[i].e_sel, tbl[i].e_host, tbl[i].e_busy,
              tbl[i].e_gfull, tbl[i].e_govf, 2'b00});
         if (tbl[i].e_sel) begin
            chk($sformatf("vec%0d_bus", i), {vif.mask, vif.addr, vif.data_out},
                {msk_of(tbl[i].e_addr), tbl[i].e_addr, dat_of(tbl[i].e_addr)});
         end
      end

      // Reset while a write is outstanding and the FIFO has overflowed.
      idle_inputs(1'b0);
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         gfx_sel_i = 1'b1; gfx_wr_i = 1'b1;
         gfx_addr_i = 16'h0400 + 16'(k); gfx_data_i = 16'h1234; gfx_mask_i = 4'h3;
         step();
         if (k == 2) chk("rst_pre_present", {vif.sel, vif.addr, busy_o}, {1'b1, 16'h0400, 1'b1});
      end
      chk("rst_pre_full", {vif.sel, gfx_full_o, gfx_overflow_o}, 3'b111);
      idle_inputs(1'b1);
      reset_i = 1'b1;
      step();
      chk("rst_mid_txn", {vif.sel, vif.wr, gfx_full_o, gfx_overflow_o, busy_o}, 5'b00000);
      reset_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("rst_post_ack%0d", k), {vif.sel, busy_o}, 2'b00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
